alu_writeback: RTL and testbench



---
 rtl/alu_writeback_if.sv | 24 ++
 rtl/alu_writeback.sv | 106 ++++++++++
 tb/tb_alu_writeback.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_writeback_if.sv
// Instruction/ALU input handshake and data-memory write bus of the writeback stage.
// master = upstream and memory side, slave = the writeback stage.
interface alu_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] alu_out;
    logic        zr;
    logic        ng;
    logic        mem_ready;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;

    modport master (
        output in_valid, instr, alu_out, zr, ng, mem_ready,
        input  in_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  in_valid, instr, alu_out, zr, ng, mem_ready,
        output in_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/alu_writeback.sv
// Hack-style writeback stage: updates A/D/PC, resolves jumps and issues memory writes.
// state    | meaning
// RUN      | accepting instructions, no write outstanding
// MEM_WAIT | write pending on the memory bus, input stalled until mem_ready
module alu_writeback (
    input  logic                  clock,
    input  logic                  reset_n,
    alu_writeback_if.slave        bus,
    output logic [15:0]           a_reg,
    output logic [15:0]           d_reg,
    output logic [15:0]           pc,
    output logic [15:0]           retired
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] retired_q, retired_d;
    logic [14:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;

    logic        accept;
    logic        jmp;
    logic [15:0] pc_inc;

    assign accept = bus.in_valid && (state_q == RUN);
    assign pc_inc = pc_q + 16'd1;
    assign jmp    = (bus.instr[2] & bus.ng)
                  | (bus.instr[1] & bus.zr)
                  | (bus.instr[0] & ~bus.ng & ~bus.zr);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        d_d         = d_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;

        case (state_q)
            RUN: begin
                if (accept) begin
                    retired_d = retired_q + 16'd1;
                    if (!bus.instr[15]) begin
                        a_d  = {1'b0, bus.instr[14:0]};
                        pc_d = pc_inc;
                    end else begin
                        if (bus.instr[5]) a_d = bus.alu_out;
                        if (bus.instr[4]) d_d = bus.alu_out;
                        // jump target and write address both come from A before this edge
                        pc_d = jmp ? a_q : pc_inc;
                        if (bus.instr[3]) begin
                            mem_addr_d  = a_q[14:0];
                            mem_wdata_d = bus.alu_out;
                            mem_we_d    = 1'b1;
                            state_d     = MEM_WAIT;
                        end
                    end
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    mem_we_d = 1'b0;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            a_q         <= 16'd0;
            d_q         <= 16'd0;
            pc_q        <= 16'd0;
            retired_q   <= 16'd0;
            mem_addr_q  <= 15'd0;
            mem_wdata_q <= 16'd0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            d_q         <= d_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign a_reg         = a_q;
    assign d_reg         = d_q;
    assign pc            = pc_q;
    assign retired       = retired_q;
endmodule

// File: tb/tb_alu_writeback.sv
// Randomised and directed bench for alu_writeback against an instruction-level reference model.
module tb_alu_writeback;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] a_reg, d_reg, pc, retired;

    int vectors = 0;
    int miscompares = 0;

    alu_writeback_if bus ();

    alu_writeback dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .a_reg   (a_reg),
        .d_reg   (d_reg),
        .pc      (pc),
        .retired (retired)
    );

    always #5 clock = ~clock;

    // reference model: architectural state of the stage
    logic [15:0] m_a, m_d, m_pc, m_ret, m_wdata;
    logic [14:0] m_addr;
    logic        m_we, m_busy;

    task automatic model_reset();
        m_a = 0; m_d = 0; m_pc = 0; m_ret = 0;
        m_addr = 0; m_wdata = 0; m_we = 0; m_busy = 0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] i, input logic [15:0] alu,
                              input logic z, input logic n, input logic mr);
        logic [15:0] old_a;
        logic        take;
        if (m_busy) begin
            if (mr) begin
                m_we = 0;
                m_busy = 0;
            end
        end else if (v) begin
            m_ret = m_ret + 16'd1;
            old_a = m_a;
            if (i[15] == 1'b0) begin
                m_a  = i & 16'h7FFF;
                m_pc = m_pc + 16'd1;
            end else begin
                take = (i[2] && n) || (i[1] && z) || (i[0] && !n && !z);
                if (i[5]) m_a = alu;
                if (i[4]) m_d = alu;
                m_pc = take ? old_a : m_pc + 16'd1;
                if (i[3]) begin
                    m_addr  = old_a[14:0];
                    m_wdata = alu;
                    m_we    = 1;
                    m_busy  = 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] i, input logic [15:0] alu,
                         input logic z, input logic n, input logic mr);
        bus.in_valid = v; bus.instr = i; bus.alu_out = alu;
        bus.zr = z; bus.ng = n; bus.mem_ready = mr;
        model_step(v, i, alu, z, n, mr);
        @(posedge clock);
        #1;
        bus.in_valid = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        #3;
        reset_n = 1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 20; k++)
            cycle($urandom_range(0, 1), 16'($urandom), 16'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        reset_n = 0;
        #2;
        model_reset();
        vectors++;
        if ({a_reg, d_reg, pc, retired} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got a=%h d=%h pc=%h ret=%h required all 0000", a_reg, d_reg, pc, retired);
        end
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 15'd0 || bus.mem_wdata !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mem: got we=%b addr=%h wdata=%h required 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        reset_n = 1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_a_then_d();
        do_reset();
        cycle(1, 16'h1234, 16'h0, 0, 0, 0);
        cycle(1, 16'hE010, 16'h1234, 0, 0, 0);
        vectors++;
        if (a_reg !== 16'h1234 || d_reg !== 16'h1234 || pc !== 16'd2 || retired !== 16'd2) begin
            miscompares++;
            $display("FAIL a_then_d: got a=%h d=%h pc=%h ret=%h required 1234 1234 0002 0002", a_reg, d_reg, pc, retired);
        end
    endtask

    task automatic test_jump_old_a();
        cycle(1, 16'h0040, 16'h0, 0, 0, 0);
        cycle(1, 16'hE027, 16'h0099, 0, 0, 0);
        vectors++;
        if (pc !== 16'h0040 || a_reg !== 16'h0099) begin
            miscompares++;
            $display("FAIL jump_old_a: got pc=%h a=%h required 0040 0099", pc, a_reg);
        end
    endtask

    task automatic test_cond_jumps();
        logic [1:0] flags [3] = '{2'b10, 2'b01, 2'b00};  // {ng, zr}
        logic [2:0] jb [3] = '{3'b100, 3'b010, 3'b001};
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 3; j++) begin
                cycle(1, 16'h0010, 16'h0, 0, 0, 0);
                cycle(1, {13'b1110000000000, jb[j]}, 16'($urandom), flags[f][0], flags[f][1], 0);
                vectors++;
                if (pc !== m_pc || pc !== ((f == j) ? 16'h0010 : m_pc)) begin
                    miscompares++;
                    $display("FAIL cond_jump ng=%b zr=%b jbits=%b: got pc=%h required %h",
                             flags[f][1], flags[f][0], jb[j], pc, m_pc);
                end
            end
        end
    endtask

    task automatic test_mem_backpressure();
        logic [15:0] ret0;
        cycle(1, 16'hE020, 16'h8005, 0, 0, 0);
        cycle(1, 16'hE008, 16'hBEEF, 0, 0, 0);
        ret0 = m_ret;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'h0005 || bus.mem_wdata !== 16'hBEEF
                || bus.in_ready !== 1'b0 || retired !== ret0) begin
                miscompares++;
                $display("FAIL mem_wait cycle %0d: got we=%b addr=%h wdata=%h rdy=%b ret=%h required 1 0005 beef 0 %h",
                         k, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.in_ready, retired, ret0);
            end
            cycle(1, 16'h0123, 16'h0, 0, 0, (k == 3));
        end
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1 || retired !== ret0) begin
            miscompares++;
            $display("FAIL mem_release: got we=%b rdy=%b ret=%h required 0 1 %h", bus.mem_we, bus.in_ready, retired, ret0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 2) != 0);
            vectors++;
            if (a_reg !== m_a || d_reg !== m_d || pc !== m_pc || retired !== m_ret || bus.mem_we !== m_we
                || bus.in_ready !== !m_busy || bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata) begin
                miscompares++;
                $display("FAIL random step %0d: got a=%h d=%h pc=%h ret=%h we=%b rdy=%b addr=%h wd=%h required %h %h %h %h %b %b %h %h",
                         k, a_reg, d_reg, pc, retired, bus.mem_we, bus.in_ready, bus.mem_addr, bus.mem_wdata,
                         m_a, m_d, m_pc, m_ret, m_we, !m_busy, m_addr, m_wdata);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 65535; k++)
            cycle(1, 16'($urandom) & 16'h7FFF, 16'h0, 0, 0, 0);
        vectors++;
        if (pc !== 16'hFFFF || retired !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL pre_wrap: got pc=%h ret=%h required ffff ffff", pc, retired);
        end
        cycle(1, 16'h0007, 16'h0, 0, 0, 0);
        vectors++;
        if (pc !== 16'h0000 || retired !== 16'h0000 || a_reg !== 16'h0007) begin
            miscompares++;
            $display("FAIL wrap: got pc=%h ret=%h a=%h required 0000 0000 0007", pc, retired, a_reg);
        end
    endtask

    task automatic test_abort();
        cycle(1, 16'h0321, 16'h0, 0, 0, 0);
        cycle(1, 16'hE008, 16'h5A5A, 0, 0, 0);
        cycle(1, 16'h0001, 16'h0, 0, 0, 0);
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'h0321) begin
            miscompares++;
            $display("FAIL abort_setup: got we=%b addr=%h required 1 0321", bus.mem_we, bus.mem_addr);
        end
        reset_n = 0;
        #1;
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort: got we=%b rdy=%b required 0 1", bus.mem_we, bus.in_ready);
        end
        reset_n = 1;
        model_reset();
        #1;
        cycle(1, 16'h0055, 16'h0, 0, 0, 0);
        vectors++;
        if (pc !== 16'd1 || a_reg !== 16'h0055 || retired !== 16'd1) begin
            miscompares++;
            $display("FAIL after_abort: got pc=%h a=%h ret=%h required 0001 0055 0001", pc, a_reg, retired);
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.instr = 0; bus.alu_out = 0;
        bus.zr = 0; bus.ng = 0; bus.mem_ready = 0;
        model_reset();
        #12;
        reset_n = 1;
        @(posedge clock);
        #1;
        test_reset();
        test_a_then_d();
        test_jump_old_a();
        test_cond_jumps();
        test_mem_backpressure();
        test_random();
        test_abort();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
